// File: rtl/out_writeback_agu.sv
// out_writeback_agu: requantizes accumulator vectors and writes them to the ofmap RAM in raster order.
// Optional clamp of negative results to zero when WB_RELU_EN is defined.
module out_writeback_agu #(
  parameter int DW = 8,
  parameter int ACC_DW = 20,
  parameter int COLS = 8,
  parameter int ADDR_DW = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [5:0]             OFMAP_DIM,
  input  logic [4:0]             OUT_CH,
  input  logic [4:0]             QSHIFT,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ACC_DW*COLS-1:0] psum_data,
  output logic                   WRenable,
  output logic [3:0]             ch_select_w,
  output logic [ADDR_DW-1:0]     ram_select_w,
  output logic [ADDR_DW-1:0]     addr_w,
  output logic [DW*COLS-1:0]     data_in,
  output logic                   busy,
  output logic                   done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE_ST} state_t;
  localparam logic signed [ACC_DW-1:0] MAXV = ACC_DW'(2 ** (DW - 1) - 1);
  localparam logic signed [ACC_DW-1:0] MINV = ACC_DW'(-(2 ** (DW - 1)));
  state_t state, state_d;
  logic [5:0] dim;
  logic [4:0] och, qs, grp;
  logic [ADDR_DW-1:0] x, y;
  logic acc, x_last, y_last, g_last, zero_cfg;
  logic [DW*COLS-1:0] q;
  assign in_ready = state == RUN;
  assign busy = state != IDLE;
  assign acc = in_valid & in_ready;
  assign x_last = 6'(x) == dim - 6'd1;
  assign y_last = 6'(y) == dim - 6'd1;
  assign g_last = 6'(grp) + 6'(COLS) >= 6'(och);
  assign zero_cfg = OFMAP_DIM == 6'd0 || OUT_CH == 5'd0;
  for (genvar k = 0; k < COLS; k++) begin : g_lane
    logic signed [ACC_DW-1:0] t;
    logic [DW-1:0] s;
    logic off;
    assign t = $signed(psum_data[k*ACC_DW +: ACC_DW]) >>> qs;
    assign s = t > MAXV ? MAXV[DW-1:0] : t < MINV ? MINV[DW-1:0] : t[DW-1:0];
    // lanes past the layer's channel count belong to a partial last group
    assign off = 6'(grp) + 6'(k) >= 6'(och);
`ifdef WB_RELU_EN
    assign q[k*DW +: DW] = (off || s[DW-1]) ? '0 : s;
`else
    assign q[k*DW +: DW] = off ? '0 : s;
`endif
  end
  always_comb begin
    state_d = state;
    state_d = state == IDLE ? (start ? (zero_cfg ? DONE_ST : RUN) : IDLE) :
              state == RUN ? ((acc && x_last && y_last && g_last) ? DONE_ST : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dim <= '0;
      och <= '0;
      qs <= '0;
      grp <= '0;
      x <= '0;
      y <= '0;
      WRenable <= 1'b0;
      ch_select_w <= '0;
      ram_select_w <= '0;
      addr_w <= '0;
      data_in <= '0;
      done <= 1'b0;
    end else begin
      state <= state_d;
      done <= state == DONE_ST;
      WRenable <= acc;
      if (state == IDLE && start) begin
        dim <= OFMAP_DIM;
        och <= OUT_CH;
        qs <= QSHIFT;
        grp <= '0;
        x <= '0;
        y <= '0;
      end
      if (acc) begin
        ch_select_w <= grp[3:0];
        ram_select_w <= x;
        addr_w <= y;
        data_in <= q;
        x <= x_last ? '0 : x + 1'b1;
        if (x_last) begin
          y <= y_last ? '0 : y + 1'b1;
          if (y_last) grp <= grp + 5'(COLS);
        end
      end
    end
  end
endmodule

// File: tb/tb_out_writeback_agu.sv
// tb_out_writeback_agu: directed scenarios with hand-computed expectations for out_writeback_agu.
module tb_out_writeback_agu;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0;
  logic [5:0] OFMAP_DIM = 0;
  logic [4:0] OUT_CH = 0, QSHIFT = 0;
  logic [159:0] psum_data = '0;
  logic in_ready, WRenable, busy, done;
  logic [3:0] ch_select_w;
  logic [4:0] ram_select_w, addr_w;
  logic [63:0] data_in;
  int errors = 0, checks = 0;

  out_writeback_agu dut (
    .clk(clk), .rst_n(rst_n), .start(start), .OFMAP_DIM(OFMAP_DIM), .OUT_CH(OUT_CH),
    .QSHIFT(QSHIFT), .in_valid(in_valid), .in_ready(in_ready), .psum_data(psum_data),
    .WRenable(WRenable), .ch_select_w(ch_select_w), .ram_select_w(ram_select_w),
    .addr_w(addr_w), .data_in(data_in), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_layer(input int d, input int o, input int s);
    OFMAP_DIM = 6'(d);
    OUT_CH = 5'(o);
    QSHIFT = 5'(s);
    start = 1;
    tick();
    start = 0;
  endtask

  function automatic logic [159:0] splat(input int v);
    logic [159:0] r;
    for (int k = 0; k < 8; k++) r[k*20 +: 20] = 20'(v);
    return r;
  endfunction

  function automatic logic [159:0] ramp();
    logic [159:0] r;
    for (int k = 0; k < 8; k++) r[k*20 +: 20] = 20'(k);
    return r;
  endfunction

  task automatic test_reset();
    logic [86:0] o;
    rst_n = 0;
    #3;
    o = {in_ready, WRenable, ch_select_w, ram_select_w, addr_w, data_in, busy, done};
    checks++; if (o !== '0) begin errors++; $display("FAIL reset_outputs: got %h exp 0", o); end
    tick();
    rst_n = 1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b exp 0", busy); end
  endtask

  task automatic test_raster();
    psum_data = ramp();
    begin_layer(2, 8, 0);
    checks++; if ({in_ready, busy} !== 2'b11) begin errors++; $display("FAIL raster_run: got %b exp 11", {in_ready, busy}); end
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({WRenable, ch_select_w, ram_select_w, addr_w, done} !== {1'b1, 4'd0, 5'(i % 2), 5'(i / 2), 1'b0}) begin
        errors++;
        $display("FAIL raster_addr%0d: got wr=%b ch=%0d x=%0d y=%0d done=%b exp wr=1 ch=0 x=%0d y=%0d done=0",
                 i, WRenable, ch_select_w, ram_select_w, addr_w, done, i % 2, i / 2);
      end
      checks++; if (data_in !== 64'h0706050403020100) begin errors++; $display("FAIL raster_data%0d: got %h exp 0706050403020100", i, data_in); end
    end
    in_valid = 0;
    tick();
    checks++; if ({WRenable, done} !== 2'b01) begin errors++; $display("FAIL raster_done: got wr/done=%b exp 01", {WRenable, done}); end
    tick();
    checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL raster_idle: got done/busy=%b exp 00", {done, busy}); end
  endtask

  task automatic test_partial_group();
    psum_data = splat(300);
    begin_layer(1, 12, 0);
    in_valid = 1;
    tick();
    checks++; if ({WRenable, ch_select_w} !== {1'b1, 4'd0}) begin errors++; $display("FAIL group0_ch: got wr=%b ch=%0d exp wr=1 ch=0", WRenable, ch_select_w); end
    checks++; if (data_in !== 64'h7f7f7f7f7f7f7f7f) begin errors++; $display("FAIL group0_data: got %h exp 7f7f7f7f7f7f7f7f", data_in); end
    tick();
    checks++; if ({WRenable, ch_select_w, ram_select_w, addr_w} !== {1'b1, 4'd8, 5'd0, 5'd0}) begin errors++; $display("FAIL group1_addr: got wr=%b ch=%0d x=%0d y=%0d exp wr=1 ch=8 x=0 y=0", WRenable, ch_select_w, ram_select_w, addr_w); end
    checks++; if (data_in !== 64'h000000007f7f7f7f) begin errors++; $display("FAIL group1_data: got %h exp 000000007f7f7f7f", data_in); end
    in_valid = 0;
    tick();
    checks++; if ({WRenable, done} !== 2'b01) begin errors++; $display("FAIL group_done: got wr/done=%b exp 01", {WRenable, done}); end
    tick();
  endtask

  task automatic test_requant();
    logic [63:0] exp_d;
`ifdef WB_RELU_EN
    exp_d = 64'h00000000007f0200;
`else
    exp_d = 64'h00000000fe7f0280;
`endif
    psum_data = '0;
    psum_data[0 +: 20] = 20'(-4000);
    psum_data[20 +: 20] = 20'd35;
    psum_data[40 +: 20] = 20'd4000;
    psum_data[60 +: 20] = 20'(-20);
    begin_layer(1, 8, 4);
    in_valid = 1;
    tick();
    in_valid = 0;
    checks++; if ({WRenable, data_in} !== {1'b1, exp_d}) begin errors++; $display("FAIL requant_data: got wr=%b data=%h exp wr=1 data=%h", WRenable, data_in, exp_d); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL requant_done: got %b exp 1", done); end
    tick();
  endtask

  task automatic test_gapped_valid();
    psum_data = ramp();
    begin_layer(2, 8, 0);
    in_valid = 1;
    tick();
    in_valid = 0;
    checks++; if ({WRenable, ram_select_w, addr_w} !== {1'b1, 5'd0, 5'd0}) begin errors++; $display("FAIL gap_w0: got wr=%b x=%0d y=%0d exp wr=1 x=0 y=0", WRenable, ram_select_w, addr_w); end
    tick();
    checks++; if ({WRenable, ram_select_w, addr_w} !== {1'b0, 5'd0, 5'd0}) begin errors++; $display("FAIL gap_idle1: got wr=%b x=%0d y=%0d exp wr=0 x=0 y=0", WRenable, ram_select_w, addr_w); end
    tick();
    in_valid = 1;
    checks++; if ({WRenable, ram_select_w, addr_w} !== {1'b0, 5'd0, 5'd0}) begin errors++; $display("FAIL gap_idle2: got wr=%b x=%0d y=%0d exp wr=0 x=0 y=0", WRenable, ram_select_w, addr_w); end
    tick();
    checks++; if ({WRenable, ram_select_w, addr_w} !== {1'b1, 5'd1, 5'd0}) begin errors++; $display("FAIL gap_w1: got wr=%b x=%0d y=%0d exp wr=1 x=1 y=0", WRenable, ram_select_w, addr_w); end
    tick();
    tick();
    in_valid = 0;
    checks++; if ({WRenable, ram_select_w, addr_w} !== {1'b1, 5'd1, 5'd1}) begin errors++; $display("FAIL gap_w3: got wr=%b x=%0d y=%0d exp wr=1 x=1 y=1", WRenable, ram_select_w, addr_w); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL gap_done: got %b exp 1", done); end
    tick();
  endtask

  task automatic test_empty_and_restart();
    in_valid = 1;
    tick();
    checks++; if ({in_ready, WRenable} !== 2'b00) begin errors++; $display("FAIL idle_drop: got ready/wr=%b exp 00", {in_ready, WRenable}); end
    in_valid = 0;
    begin_layer(2, 0, 0);
    checks++; if ({busy, WRenable, done} !== 3'b100) begin errors++; $display("FAIL empty_c1: got busy/wr/done=%b exp 100", {busy, WRenable, done}); end
    tick();
    checks++; if ({WRenable, done} !== 2'b01) begin errors++; $display("FAIL empty_c2: got wr/done=%b exp 01", {WRenable, done}); end
    tick();
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL empty_c3: got busy/done=%b exp 00", {busy, done}); end
    begin_layer(2, 8, 0);
    in_valid = 1;
    tick();
    OFMAP_DIM = 6'd1;
    OUT_CH = 5'd0;
    start = 1;
    tick();
    start = 0;
    checks++; if ({WRenable, ram_select_w, addr_w, busy} !== {1'b1, 5'd1, 5'd0, 1'b1}) begin errors++; $display("FAIL restart_ignored1: got wr=%b x=%0d y=%0d busy=%b exp 1 1 0 1", WRenable, ram_select_w, addr_w, busy); end
    tick();
    checks++; if ({WRenable, ram_select_w, addr_w} !== {1'b1, 5'd0, 5'd1}) begin errors++; $display("FAIL restart_ignored2: got wr=%b x=%0d y=%0d exp 1 0 1", WRenable, ram_select_w, addr_w); end
    tick();
    in_valid = 0;
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL restart_done: got %b exp 1", done); end
    tick();
  endtask

  task automatic test_midlayer_reset();
    logic [86:0] o;
    psum_data = ramp();
    begin_layer(2, 16, 0);
    in_valid = 1;
    tick();
    tick();
    tick();
    checks++; if ({WRenable, ram_select_w, addr_w} !== {1'b1, 5'd0, 5'd1}) begin errors++; $display("FAIL mid_w2: got wr=%b x=%0d y=%0d exp 1 0 1", WRenable, ram_select_w, addr_w); end
    rst_n = 0;
    #1;
    o = {in_ready, WRenable, ch_select_w, ram_select_w, addr_w, data_in, busy, done};
    checks++; if (o !== '0) begin errors++; $display("FAIL mid_reset: got %h exp 0", o); end
    in_valid = 0;
    #2;
    rst_n = 1;
    tick();
    checks++; if ({WRenable, done, busy} !== 3'b000) begin errors++; $display("FAIL mid_after: got wr/done/busy=%b exp 000", {WRenable, done, busy}); end
    begin_layer(2, 16, 0);
    in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({WRenable, ch_select_w, ram_select_w, addr_w} !== {1'b1, 4'((i / 4) * 8), 5'(i % 2), 5'((i / 2) % 2)}) begin
        errors++;
        $display("FAIL fresh_w%0d: got wr=%b ch=%0d x=%0d y=%0d exp wr=1 ch=%0d x=%0d y=%0d",
                 i, WRenable, ch_select_w, ram_select_w, addr_w, (i / 4) * 8, i % 2, (i / 2) % 2);
      end
    end
    in_valid = 0;
    tick();
    checks++; if ({WRenable, done} !== 2'b01) begin errors++; $display("FAIL fresh_done: got wr/done=%b exp 01", {WRenable, done}); end
    tick();
  endtask

  initial begin
    test_reset();
    test_raster();
    test_partial_group();
    test_requant();
    test_gapped_valid();
    test_empty_and_restart();
    test_midlayer_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
